pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 4, meaning multiply latency in cycles (legal 1..16).
REQ-002 Parameter GPIO_CH, default 4, meaning number of GPIO write channels (legal 1..32).
REQ-003 clk  input  1  meaning single rising-edge clock.
REQ-004 rst  input  1  meaning asynchronous, active-low reset.
REQ-005 instr_valid  input  1  meaning instruction is valid this cycle.
REQ-006 instruction  input  32  meaning MIPS word from FETCH; opcode [31:26], rd [15:11], shamt [10:6], funct [5:0].
REQ-007 zero_EX  input  1  meaning ALU zero flag for the instruction currently in EX.
REQ-008 op_EX  output  4  meaning ALU operation.
REQ-009 shamt_EX  output  5  meaning shift amount.
REQ-010 regsel_EX  output  2  meaning writeback select: 0 ALU, 1 HI, 2 LO.
REQ-011 enhilo_EX, regwrite_EX, rdrt_EX, illegal_EX  output  1 each  meaning HI/LO enable, register write, rt-destination select, undecodable instruction.
REQ-012 alu_src_EX  output  2  meaning B operand: 0 register, 1 sign-extended immediate, 2 zero-extended immediate.
REQ-013 pc_src_EX  output  2  meaning 0 PC+4, 1 branch target.
REQ-014 stall_FETCH  output  1  meaning FETCH holds PC and instruction.
REQ-015 gpio_we_EX  output  GPIO_CH  meaning one-hot GPIO channel write enable.

Function
REQ-016 All *_EX outputs except pc_src_EX shall be registered; a decode is loaded on each rising edge when state is RUN, stall_FETCH=0, and instr_valid=1.
REQ-017 When instr_valid=0, the block shall load a bubble (all EX controls 0).
REQ-018 R-type decode (opcode 0):
  - funct 100000/100001 -> op 0100, regwrite
  - funct 100010/100011 -> op 0101, regwrite
  - funct 100100 -> op 0000, regwrite
  - funct 100101 -> op 0001, regwrite
  - funct 011000 -> op 0110, enhilo
  - funct 011001 -> op 0111, enhilo
  - funct 000000 -> op 1000, shamt_EX=shamt, regwrite
  - funct 010000 -> regsel 1, regwrite
  - funct 010010 -> regsel 2, regwrite
REQ-019 srl (funct 000010) with shamt≠0 shall decode as op 1001, shamt_EX=shamt, regwrite.
REQ-020 srl with shamt=0 shall be a GPIO write: gpio_we_EX[rd]=1 if rd<GPIO_CH, otherwise illegal_EX=1; regwrite=0.
REQ-021 I-type decode:
  - opcode 001000/001001 -> op 0100, alu_src 1, rdrt, regwrite
  - opcode 001111 -> op 1000, shamt 16, alu_src 1, rdrt, regwrite
  - opcode 001101 -> op 0001, alu_src 2, rdrt, regwrite
  - opcode 000101 (bne) and 000100 (beq) -> op 0101, internal branch flag and type
REQ-022 Any other encoding shall load illegal_EX=1 with all other controls 0.
REQ-023 States shall be RUN, MUL_WAIT and FLUSH, with a 4-bit down-counter cnt.
REQ-024 Branch taken condition in RUN: bne with zero_EX=0, or beq with zero_EX=1.
  - pc_src_EX=1 and stall_FETCH=1, combinationally, same cycle.
  - Next edge: EX loads a bubble; state -> FLUSH.
REQ-025 Branch not taken: no stall, normal load.
REQ-026 FLUSH shall last exactly one cycle: pc_src_EX=0, stall_FETCH=0, normal load; state -> RUN.
REQ-027 Edge loading mult/multu when MULT_LAT>1: state -> MUL_WAIT, cnt <- MULT_LAT-1.
REQ-028 In MUL_WAIT:
  - stall_FETCH=1.
  - Each edge loads a bubble and decrements cnt.
  - The edge where cnt==1 returns state to RUN.
  - Total MULT_LAT-1 bubble cycles.
REQ-029 With MULT_LAT=1, mult shall cause no stall.
REQ-030 Back-to-back mult after MUL_WAIT shall re-enter MUL_WAIT with cnt reloaded.
REQ-031 In MUL_WAIT or FLUSH, pc_src_EX shall be 0 and the branch flag shall be ignored (EX holds a bubble).

Reset
REQ-032 rst low shall asynchronously force state RUN, cnt 0, every output 0 (including stall_FETCH, pc_src_EX, gpio_we_EX), and the branch flag 0.
REQ-033 Reset asserted mid-MUL_WAIT or FLUSH shall abort the operation with no residual stall after release.
REQ-034 The first edge after rst rises shall perform a normal RUN load.

Verification
REQ-035 add $3,$1,$2 (0x00221820), valid -> next cycle op_EX=0100, regwrite_EX=1, regsel_EX=0, stall_FETCH=0.
REQ-036 bne in EX with zero_EX=0 -> same cycle pc_src_EX=1, stall_FETCH=1; next cycle EX all 0; the following cycle the next instruction loads normally; with zero_EX=1 -> no stall.
REQ-037 mult with MULT_LAT=4 followed by mflo -> enhilo_EX=1 for one cycle, stall_FETCH=1 for 3 cycles with EX bubbles, then regsel_EX=2, regwrite_EX=1.
REQ-038 srl rd=2, shamt=0, GPIO_CH=4 -> gpio_we_EX=0100; rd=7 -> illegal_EX=1, gpio_we_EX=0.
REQ-039 lui -> shamt_EX=16, op_EX=1000, alu_src_EX=1, rdrt_EX=1.
REQ-040 Reset pulse during cycle 2 of MUL_WAIT -> all outputs 0 immediately; after release the next valid add decodes in one cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Decode and hazard control for the EX stage of a MIPS-style pipeline.
// Registers EX controls, resolves branches in EX and stalls FETCH on branch flush or multiply.
module pipeline_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int GPIO_CH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instruction,
  input  logic               zero_EX,
  output logic [3:0]         op_EX,
  output logic [4:0]         shamt_EX,
  output logic [1:0]         regsel_EX,
  output logic               enhilo_EX,
  output logic               regwrite_EX,
  output logic               rdrt_EX,
  output logic               illegal_EX,
  output logic [1:0]         alu_src_EX,
  output logic [1:0]         pc_src_EX,
  output logic               stall_FETCH,
  output logic [GPIO_CH-1:0] gpio_we_EX
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH} state_t;

  typedef struct packed {
    logic [3:0]         op;
    logic [4:0]         shamt;
    logic [1:0]         regsel;
    logic               enhilo;
    logic               regwrite;
    logic               rdrt;
    logic               illegal;
    logic [1:0]         alu_src;
    logic               br;
    logic               bne;
    logic [GPIO_CH-1:0] gpio_we;
  } ctrl_t;

  localparam logic [3:0] CNT_INIT  = 4'(MULT_LAT - 1);
  localparam logic       MUL_STALL = (MULT_LAT > 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  ctrl_t      ctrl_p0, ctrl_d, dec;
  logic       take, load;
  logic       unused_fields;

  assign unused_fields = ^instruction[25:16];

  function automatic ctrl_t decode(input logic [5:0] opc, input logic [4:0] rd,
                                   input logic [4:0] sh, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (opc)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100001: begin c.op = 4'b0100; c.regwrite = 1'b1; end
          6'b100010, 6'b100011: begin c.op = 4'b0101; c.regwrite = 1'b1; end
          6'b100100: begin c.op = 4'b0000; c.regwrite = 1'b1; end
          6'b100101: begin c.op = 4'b0001; c.regwrite = 1'b1; end
          6'b011000: begin c.op = 4'b0110; c.enhilo = 1'b1; end
          6'b011001: begin c.op = 4'b0111; c.enhilo = 1'b1; end
          6'b000000: begin c.op = 4'b1000; c.shamt = sh; c.regwrite = 1'b1; end
          6'b010000: begin c.regsel = 2'd1; c.regwrite = 1'b1; end
          6'b010010: begin c.regsel = 2'd2; c.regwrite = 1'b1; end
          6'b000010: begin
            if (sh != 5'd0) begin
              c.op = 4'b1001; c.shamt = sh; c.regwrite = 1'b1;
            end else if (int'(rd) < GPIO_CH) begin
              // srl with zero shift is repurposed as a GPIO channel strobe
              for (int i = 0; i < GPIO_CH; i++)
                if (int'(rd) == i) c.gpio_we[i] = 1'b1;
            end else begin
              c.illegal = 1'b1;
            end
          end
          default: c.illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin
        c.op = 4'b0100; c.alu_src = 2'd1; c.rdrt = 1'b1; c.regwrite = 1'b1;
      end
      6'b001111: begin
        c.op = 4'b1000; c.shamt = 5'd16; c.alu_src = 2'd1; c.rdrt = 1'b1; c.regwrite = 1'b1;
      end
      6'b001101: begin
        c.op = 4'b0001; c.alu_src = 2'd2; c.rdrt = 1'b1; c.regwrite = 1'b1;
      end
      6'b000101: begin c.op = 4'b0101; c.br = 1'b1; c.bne = 1'b1; end
      6'b000100: begin c.op = 4'b0101; c.br = 1'b1; end
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Branch resolution in EX and next-state / next-EX selection
  always_comb begin
    take    = (state == RUN) && ctrl_p0.br && (ctrl_p0.bne ? !zero_EX : zero_EX);
    load    = (state != MUL_WAIT) && !take && instr_valid;
    dec     = decode(instruction[31:26], instruction[15:11], instruction[10:6], instruction[5:0]);
    ctrl_d  = load ? dec : '0;
    state_d = state;
    cnt_d   = cnt;
    case (state)
      RUN, FLUSH: begin
        if (take) begin
          state_d = FLUSH;
        end else if (load && dec.enhilo && MUL_STALL) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = RUN;
        end
      end
      MUL_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt <= 4'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // EX stage register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      cnt     <= 4'd0;
      ctrl_p0 <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ctrl_p0 <= ctrl_d;
    end
  end

  assign op_EX       = ctrl_p0.op;
  assign shamt_EX    = ctrl_p0.shamt;
  assign regsel_EX   = ctrl_p0.regsel;
  assign enhilo_EX   = ctrl_p0.enhilo;
  assign regwrite_EX = ctrl_p0.regwrite;
  assign rdrt_EX     = ctrl_p0.rdrt;
  assign illegal_EX  = ctrl_p0.illegal;
  assign alu_src_EX  = ctrl_p0.alu_src;
  assign gpio_we_EX  = ctrl_p0.gpio_we;
  assign pc_src_EX   = {1'b0, take};
  assign stall_FETCH = take || (state == MUL_WAIT);

endmodule
